// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en;
  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output pc_en, pc_write, branch, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  pc_en, pc_write, branch, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main Moore control FSM for the multicycle MIPS datapath
module mips_multicycle_control (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_control_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Plain vector register so codes 12-15 are representable and recover cleanly.
  logic [3:0] state_q;
  state_t     cur;
  state_t     nxt;

  logic       pc_write_c, branch_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c, illegal_op_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;

  assign cur = state_t'(state_q);

  // State register: reset always returns to FETCH, abandoning any instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= nxt;
  end

  // Next-state and Moore output decode from the current state.
  always_comb begin
    nxt          = S_FETCH;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_src_c     = 2'b00;
    illegal_op_c = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_write_c  = 1'b1;
        nxt         = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            nxt          = S_FETCH;
            illegal_op_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        nxt         = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        nxt        = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        branch_c    = 1'b1;
        pc_src_c    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        nxt         = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset masks every strobe so no write leaks out while the FSM is being cleared.
  assign bus.pc_write   = ~reset & pc_write_c;
  assign bus.branch     = ~reset & branch_c;
  assign bus.iord       = ~reset & iord_c;
  assign bus.mem_read   = ~reset & mem_read_c;
  assign bus.mem_write  = ~reset & mem_write_c;
  assign bus.ir_write   = ~reset & ir_write_c;
  assign bus.mem_to_reg = ~reset & mem_to_reg_c;
  assign bus.reg_dst    = ~reset & reg_dst_c;
  assign bus.reg_write  = ~reset & reg_write_c;
  assign bus.alu_src_a  = ~reset & alu_src_a_c;
  assign bus.illegal_op = ~reset & illegal_op_c;
  assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
  assign bus.alu_op     = reset ? 2'b00 : alu_op_c;
  assign bus.pc_src     = reset ? 2'b00 : pc_src_c;
  assign bus.pc_en      = ~reset & (pc_write_c | (branch_c & bus.zero));
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - self-checking bench for mips_multicycle_control
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [5:0]      op;
    int              zmode;
    int              len;
    logic [4:0][3:0] path;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Collect the live outputs into one comparable word.
  function automatic outs_t sample_outs();
    outs_t o;
    o.pc_write   = bus.pc_write;
    o.branch     = bus.branch;
    o.iord       = bus.iord;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_dst    = bus.reg_dst;
    o.reg_write  = bus.reg_write;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.pc_src     = bus.pc_src;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  // Expected output word for each step of the instruction sequence.
  function automatic outs_t exp_outs(input logic [3:0] s, input logic ill);
    outs_t o;
    o = '0;
    case (s)
      4'd0:  begin o.mem_read = 1'b1; o.ir_write = 1'b1; o.alu_src_b = 2'b01; o.pc_write = 1'b1; end
      4'd1:  begin o.alu_src_b = 2'b11; o.illegal_op = ill; end
      4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
      4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      4'd5:  begin o.mem_write = 1'b1; o.iord = 1'b1; end
      4'd6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      4'd8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.branch = 1'b1; o.pc_src = 2'b01; end
      4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd10: begin o.reg_write = 1'b1; end
      4'd11: begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  // Reference walk: every instruction is fetch, decode, then its class-specific steps.
  function automatic int path_of(input logic [5:0] op, output logic [4:0][3:0] p);
    int q[$];
    q.push_back(0);
    q.push_back(1);
    case (op)
      6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      6'b101011: begin q.push_back(2); q.push_back(5); end
      6'b000000: begin q.push_back(6); q.push_back(7); end
      6'b001000: begin q.push_back(9); q.push_back(10); end
      6'b000100: q.push_back(8);
      6'b000010: q.push_back(11);
      default: ;
    endcase
    p = '0;
    foreach (q[k]) p[k] = 4'(q[k]);
    return q.size();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Walk one instruction from its FETCH cycle; afterwards the FSM must be back in FETCH.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int len,
                           input logic [4:0][3:0] path);
    outs_t o;
    logic  ill;
    ill = !is_legal(op);
    bus.opcode = op;
    for (int k = 0; k < len; k++) begin
      if (zmode == 2) bus.zero = 1'($urandom_range(0, 1));
      else            bus.zero = (zmode == 1);
      #1;
      o = exp_outs(path[k], ill);
      check("state", 32'(bus.state), 32'(path[k]));
      check("outputs", 32'(sample_outs()), 32'(o));
      check("pc_en", 32'(bus.pc_en), 32'(o.pc_write | (o.branch & bus.zero)));
      @(negedge clk);
    end
    #1;
    check("return_to_fetch", 32'(bus.state), 32'd0);
  endtask

  // Safety invariants sampled every cycle.
  always @(negedge clk) begin
    check("mem_rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
    check("reg_pc_write_exclusive", 32'(bus.reg_write & bus.pc_write), 32'd0);
  end

  vec_t            tbl[9];
  logic [4:0][3:0] rp;
  int              rlen;
  logic [5:0]      ops[6];

  initial begin
    tbl[0] = '{6'b100011, 0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
    tbl[1] = '{6'b101011, 0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
    tbl[2] = '{6'b000000, 1, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
    tbl[3] = '{6'b001000, 0, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
    tbl[4] = '{6'b000010, 0, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
    tbl[5] = '{6'b000100, 1, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    tbl[6] = '{6'b000100, 0, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
    tbl[7] = '{6'b111111, 1, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
    tbl[8] = '{6'b000001, 0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    bus.opcode = 6'b000000;
    bus.zero   = 1'b1;

    // Outputs are forced quiet while reset is held.
    repeat (2) begin
      @(negedge clk);
      #1;
      check("reset_outputs", 32'(sample_outs()), 32'd0);
      check("reset_pc_en", 32'(bus.pc_en), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 32'(bus.state), 32'd0);

    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].zmode, tbl[i].len, tbl[i].path);

    // Reset held three cycles in the middle of an R-type EXEC step.
    bus.opcode = 6'b000000;
    bus.zero   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reach_exec", 32'(bus.state), 32'd6);
    reset = 1'b1;
    repeat (3) begin
      #1;
      check("midreset_outputs", 32'(sample_outs()), 32'd0);
      check("midreset_pc_en", 32'(bus.pc_en), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("post_reset_state", 32'(bus.state), 32'd0);
    check("post_reset_outputs", 32'(sample_outs()), 32'(exp_outs(4'd0, 1'b0)));
    check("post_reset_pc_en", 32'(bus.pc_en), 32'd1);

    // An unused state code must show no activity and recover to FETCH.
    force dut.state_q = 4'd13;
    #1;
    check("unused_state_outputs", 32'(sample_outs()), 32'd0);
    check("unused_state_pc_en", 32'(bus.pc_en), 32'd0);
    release dut.state_q;
    @(negedge clk);
    #1;
    check("unused_state_recover", 32'(bus.state), 32'd0);

    // Random legal instruction stream with a random zero flag each cycle.
    for (int i = 0; i < 1000; i++) begin
      bus.opcode = ops[$urandom_range(0, 5)];
      rlen = path_of(bus.opcode, rp);
      run_instr(bus.opcode, 2, rlen, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
